vmicro16_apb_master: RTL and testbench
======================================

// Module: vmicro16_apb_master
// PURPOSE
//  Core-side APB initiator. Turns a simple valid/ready request (addr, write, wdata)
//  from one core into an APB SETUP/ACCESS transfer and returns read data as a response.
//  Its M_* outputs drive one master port (S_* inputs) of the APB interconnect.
//  Guarantees a PSELx-low gap between transfers so the interconnect arbiter can rotate.
//  Has an optional wait-state timeout so a missing slave cannot hang the core.
// PARAMETERS
//  BUS_WIDTH   16   APB address width
//  DATA_WIDTH  16   APB data width
//  TIMEOUT     255  max ACCESS cycles waiting for PREADY; 0 = never time out
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  req_valid    in   1           core requests a transfer
//  req_ready    out  1           block can accept a request (high only in IDLE)
//  req_addr     in   BUS_WIDTH   transfer address
//  req_write    in   1           1 = write, 0 = read
//  req_wdata    in   DATA_WIDTH  write data
//  rsp_valid    out  1           one-cycle pulse: transfer finished
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes and on timeout)
//  rsp_timeout  out  1           qualifies rsp_valid: transfer aborted by timeout
//  M_PADDR      out  BUS_WIDTH   APB address
//  M_PWRITE     out  1           APB write strobe
//  M_PSELx      out  1           APB select
//  M_PENABLE    out  1           APB enable
//  M_PWDATA     out  DATA_WIDTH  APB write data
//  M_PRDATA     in   DATA_WIDTH  APB read data
//  M_PREADY     in   1           APB ready
// BEHAVIOUR
//  - States: IDLE, SETUP, ACCESS. All outputs are registered except req_ready = (state==IDLE).
//  - Reset (asynchronous): state=IDLE. All outputs are 0, including M_PADDR and M_PWDATA.
//    Timeout counter = 0. A transfer in flight is dropped and produces no rsp_valid.
//  - IDLE: M_PSELx=0, M_PENABLE=0.
//    If req_valid is high at the edge: register addr/write/wdata and go to SETUP.
//    req_* are sampled only at acceptance.
//  - SETUP (1 cycle): M_PSELx=1, M_PENABLE=0. M_PREADY is ignored. Go to ACCESS.
//  - ACCESS: M_PSELx=1, M_PENABLE=1. Address, data and write are held stable.
//    Counter increments each ACCESS cycle in which M_PREADY is low.
//    M_PREADY high: for reads rsp_rdata<=M_PRDATA, for writes 0. rsp_valid<=1, rsp_timeout<=0.
//    Then go to IDLE, dropping PSELx and PENABLE on the same edge.
//    TIMEOUT!=0 and counter reaches TIMEOUT with M_PREADY low: rsp_valid<=1, rsp_timeout<=1,
//    rsp_rdata<=0, go to IDLE.
//    M_PREADY and timeout on the same edge: PREADY wins and the transfer completes normally.
//  - Latency, accept edge to rsp_valid high: 3 cycles + N wait states.
//  - rsp_valid is high for exactly one cycle. That cycle is IDLE, so a new request
//    can be accepted in the same cycle.
//  - Minimum gap: M_PSELx is low for at least 1 cycle between transfers.
//    Peak throughput is 1 transfer per 3 cycles.
//  - Timeout counter is clog2(TIMEOUT+1) bits, cleared on entry to SETUP, saturates.
//  - M_PADDR, M_PWDATA and M_PWRITE hold their last value in IDLE.
//    rsp_rdata holds until the next response.
// TESTING
//  1. Zero-wait write, addr=0x0010, wdata=0xBEEF, accepted at cycle 0:
//     PSELx=1 at cycle 1, PENABLE=1 at cycle 2 with PREADY=1;
//     cycle 3: PSELx=0, rsp_valid=1, rsp_timeout=0.
//  2. Read addr=0x0100 with PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234:
//     rsp_valid at cycle 6, rsp_rdata=0x1234; PADDR stable cycles 1-5.
//  3. TIMEOUT=4 with PREADY held at 0: exactly 4 ACCESS cycles, then PSELx=0,
//     rsp_valid=1, rsp_timeout=1, rsp_rdata=0. Repeat with TIMEOUT=0: no abort after 1000 cycles.
//  4. req_valid held high for 3 transfers while PREADY=1 during SETUP:
//     SETUP PREADY is ignored; PSELx is low exactly 1 cycle between transfers;
//     rsp_valid every 3 cycles.
//  5. reset asserted mid-ACCESS, asynchronously between edges: PSELx, PENABLE and
//     req_ready go to reset values immediately; no rsp_valid. A read after release completes normally.
//  6. Two instances on an APB interconnect with 2 masters and GPIO/BRAM slaves, interleaved
//     writes then readback: every read returns the value written and no transfer hangs.

Source files
------------

// File: rtl/vmicro16_apb_master.sv
// Core-side APB initiator: converts a valid/ready request into one SETUP/ACCESS
// transfer and returns a single-cycle response, with an optional wait-state timeout.
module vmicro16_apb_master #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,

    output logic [BUS_WIDTH-1:0]  M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the edge that would bring the count up to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [BUS_WIDTH-1:0]  paddr_next;
    logic                  pwrite_next;
    logic                  psel_next;
    logic                  penable_next;
    logic [DATA_WIDTH-1:0] pwdata_next;
    logic                  rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_next;
    logic                  rsp_timeout_next;

    assign req_ready = (state == IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next       = state;
        cnt_next         = cnt;
        paddr_next       = M_PADDR;
        pwrite_next      = M_PWRITE;
        pwdata_next      = M_PWDATA;
        psel_next        = M_PSELx;
        penable_next     = M_PENABLE;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata;
        rsp_timeout_next = rsp_timeout;

        unique case (state)
            IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (req_valid) begin
                    state_next  = SETUP;
                    paddr_next  = req_addr;
                    pwrite_next = req_write;
                    pwdata_next = req_wdata;
                    psel_next   = 1'b1;
                    cnt_next    = '0;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end
            ACCESS: begin
                if (M_PREADY) begin
                    state_next       = IDLE;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_timeout_next = 1'b0;
                    rsp_rdata_next   = M_PWRITE ? '0 : M_PRDATA;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_next       = IDLE;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            M_PADDR     <= '0;
            M_PWRITE    <= 1'b0;
            M_PSELx     <= 1'b0;
            M_PENABLE   <= 1'b0;
            M_PWDATA    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            M_PADDR     <= paddr_next;
            M_PWRITE    <= pwrite_next;
            M_PSELx     <= psel_next;
            M_PENABLE   <= penable_next;
            M_PWDATA    <= pwdata_next;
            rsp_valid   <= rsp_valid_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_timeout <= rsp_timeout_next;
        end
    end

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Bench for vmicro16_apb_master: two masters (TIMEOUT=4 and TIMEOUT=0) on a
// behavioural APB slave/interconnect with a BRAM and a GPIO register.
module tb_vmicro16_apb_master;

    localparam int TO_A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    wire  [1:0]  req_ready, rsp_valid, rsp_timeout, psel, penable, pwrite, pready;
    wire  [15:0] rsp_rdata [2];
    wire  [15:0] paddr     [2];
    wire  [15:0] pwdata    [2];
    wire  [15:0] prdata    [2];

    vmicro16_apb_master #(.BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(TO_A)) u_a (
        .clk(clk), .reset(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_write(req_write[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_timeout(rsp_timeout[0]),
        .M_PADDR(paddr[0]), .M_PWRITE(pwrite[0]), .M_PSELx(psel[0]), .M_PENABLE(penable[0]),
        .M_PWDATA(pwdata[0]), .M_PRDATA(prdata[0]), .M_PREADY(pready[0])
    );

    vmicro16_apb_master #(.BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_write(req_write[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_timeout(rsp_timeout[1]),
        .M_PADDR(paddr[1]), .M_PWRITE(pwrite[1]), .M_PSELx(psel[1]), .M_PENABLE(penable[1]),
        .M_PWDATA(pwdata[1]), .M_PRDATA(prdata[1]), .M_PREADY(pready[1])
    );

    // ---------------- slave / interconnect model ----------------
    logic        shared, setup_ready, mem_init;
    logic [1:0]  stuck;
    int          waits   [2];
    int          acc_cnt [2];
    logic [15:0] bram [256];
    logic [15:0] gpio;
    logic        owner_v, owner, gnt_v, gnt;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 3 + 256);
    endfunction

    // Fixed priority is enough: the master's PSELx gap hands the bus over.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = 1'b0;
        if (owner_v && psel[owner]) begin gnt_v = 1'b1; gnt = owner; end
        else if (psel[0])           begin gnt_v = 1'b1; gnt = 1'b0;  end
        else if (psel[1])           begin gnt_v = 1'b1; gnt = 1'b1;  end
    end

    for (genvar m = 0; m < 2; m++) begin : g_slv
        wire sel_ok = !shared || (gnt_v && (gnt == 1'(m)));
        assign pready[m] = psel[m] && sel_ok &&
                           (penable[m] ? ((acc_cnt[m] >= waits[m]) && !stuck[m]) : setup_ready);
        assign prdata[m] = paddr[m][15] ? gpio : bram[paddr[m][7:0]];
    end

    always @(posedge clk) begin
        owner_v <= gnt_v;
        owner   <= gnt;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
            gpio <= 16'h0000;
        end
        for (int m = 0; m < 2; m++) begin
            if (psel[m] && penable[m] && !pready[m]) acc_cnt[m] <= acc_cnt[m] + 1;
            else if (!psel[m])                       acc_cnt[m] <= 0;
            if (psel[m] && penable[m] && pready[m] && pwrite[m]) begin
                if (paddr[m][15]) gpio <= pwdata[m];
                else              bram[paddr[m][7:0]] <= pwdata[m];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] ref_mem [257];

    function automatic int key(input logic [15:0] a);
        return a[15] ? 256 : int'(a[7:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // While PSELx stays high, the transfer's address/data/direction must not move.
    logic        mon_en, mon_psel, mon_wr;
    logic [15:0] mon_addr, mon_wd;
    always @(negedge clk) begin
        if (mon_en && mon_psel && psel[0]) begin
            check("mon_paddr_stable", paddr[0], mon_addr);
            check("mon_pwdata_stable", pwdata[0], mon_wd);
            check("mon_pwrite_stable", pwrite[0], mon_wr);
            check("mon_penable", penable[0], 1);
        end
        mon_psel <= psel[0];
        mon_addr <= paddr[0];
        mon_wd   <= pwdata[0];
        mon_wr   <= pwrite[0];
    end

    // Issue one request on master m; lat is the cycle number (accept cycle = 0) of rsp_valid.
    task automatic xfer(input int m, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic to, output int lat, output logic done);
        int n;
        @(negedge clk);
        req_valid[m] = 1'b1;
        req_write[m] = wr;
        req_addr[m]  = addr;
        req_wdata[m] = wd;
        n = 0;
        while (!req_ready[m] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[m] = 1'b0;
        req_write[m] = 1'($urandom);
        req_addr[m]  = 16'($urandom);
        req_wdata[m] = 16'($urandom);
        lat = 1;
        while (!rsp_valid[m] && lat < 40) begin @(negedge clk); lat++; end
        done = rsp_valid[m];
        rd   = rsp_rdata[m];
        to   = rsp_timeout[m];
    endtask

    task automatic run(input string nm, input int m, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_to,
                       input int exp_lat);
        logic [15:0] rd;
        logic        to, done;
        int          lat;
        xfer(m, wr, addr, wd, rd, to, lat, done);
        check({nm, "_done"}, done, 1);
        if (done) begin
            check({nm, "_rdata"}, rd, exp_rd);
            check({nm, "_timeout"}, to, exp_to);
            if (exp_lat > 0) check({nm, "_latency"}, lat, exp_lat);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        int          w;
        logic [15:0] exp_rd;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [9];
    logic [15:0] sh_a [6];
    logic [15:0] sh_b [6];
    int          bad;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rows run on master 0 (TIMEOUT=4); 3 waits completes, 4+ waits aborts after 4 ACCESS cycles
        tbl[0] = '{1'b1, 16'h0100, 16'h1234, 0, 16'h0000, 1'b0, 3};
        tbl[1] = '{1'b0, 16'h0100, 16'h0000, 3, 16'h1234, 1'b0, 6};
        tbl[2] = '{1'b1, 16'h0020, 16'h1111, 0, 16'h0000, 1'b0, 3};
        tbl[3] = '{1'b0, 16'h0020, 16'h0000, 4, 16'h0000, 1'b1, 6};
        tbl[4] = '{1'b0, 16'h0020, 16'h0000, 3, 16'h1111, 1'b0, 6};
        tbl[5] = '{1'b1, 16'h8000, 16'hA5A5, 1, 16'h0000, 1'b0, 4};
        tbl[6] = '{1'b0, 16'h8000, 16'h0000, 2, 16'hA5A5, 1'b0, 5};
        tbl[7] = '{1'b1, 16'h0030, 16'h7777, 5, 16'h0000, 1'b1, 6};
        tbl[8] = '{1'b0, 16'h0030, 16'h0000, 0, 16'h0190, 1'b0, 3};

        req_valid = '0;
        req_write = '0;
        for (int m = 0; m < 2; m++) begin
            req_addr[m] = '0; req_wdata[m] = '0; waits[m] = 0; acc_cnt[m] = 0;
        end
        shared = 1'b0; setup_ready = 1'b0; stuck = '0; mem_init = 1'b1; mon_en = 1'b0;
        owner_v = 1'b0; owner = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_mem[256] = 16'h0000;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_req_ready", req_ready, 2'b11);
        check("rst_paddr", paddr[0], 0);
        check("rst_pwdata", pwdata[0], 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rsp_rdata", rsp_rdata[0], 0);
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // zero-wait write, cycle by cycle
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'hBEEF;
        @(negedge clk);
        req_valid[0] = 1'b0; req_addr[0] = 16'hFFFF; req_wdata[0] = 16'h0000; req_write[0] = 1'b0;
        check("t1_c1_psel", psel[0], 1);
        check("t1_c1_penable", penable[0], 0);
        check("t1_c1_req_ready", req_ready[0], 0);
        check("t1_c1_paddr", paddr[0], 16'h0010);
        check("t1_c1_pwdata", pwdata[0], 16'hBEEF);
        check("t1_c1_pwrite", pwrite[0], 1);
        @(negedge clk);
        check("t1_c2_psel", psel[0], 1);
        check("t1_c2_penable", penable[0], 1);
        check("t1_c2_rsp_valid", rsp_valid[0], 0);
        @(negedge clk);
        check("t1_c3_psel", psel[0], 0);
        check("t1_c3_penable", penable[0], 0);
        check("t1_c3_rsp_valid", rsp_valid[0], 1);
        check("t1_c3_rsp_timeout", rsp_timeout[0], 0);
        check("t1_c3_rsp_rdata", rsp_rdata[0], 0);
        check("t1_c3_req_ready", req_ready[0], 1);
        check("t1_c3_paddr_hold", paddr[0], 16'h0010);
        @(negedge clk);
        check("t1_c4_rsp_valid", rsp_valid[0], 0);
        ref_mem[key(16'h0010)] = 16'hBEEF;

        // table: wait states, timeout boundary, PREADY-vs-timeout tie, GPIO
        for (int i = 0; i < 9; i++) begin
            waits[0] = tbl[i].w;
            run($sformatf("tbl%0d", i), 0, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                tbl[i].exp_rd, tbl[i].exp_to, tbl[i].exp_lat);
            if (tbl[i].wr && !tbl[i].exp_to) ref_mem[key(tbl[i].addr)] = tbl[i].wd;
        end
        waits[0] = 0;

        // TIMEOUT=0: stuck slave never aborts, then completes once PREADY arrives
        stuck[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'h0010;
        @(negedge clk);
        req_valid[1] = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rsp_valid[1] || !psel[1] || !penable[1]) bad++;
        end
        check("t3_no_abort_bad_cycles", bad, 0);
        stuck[1] = 1'b0;
        @(negedge clk);
        check("t3_late_rsp_valid", rsp_valid[1], 1);
        check("t3_late_rsp_timeout", rsp_timeout[1], 0);
        check("t3_late_rsp_rdata", rsp_rdata[1], ref_mem[key(16'h0010)]);

        // back-to-back requests with PREADY high during SETUP
        setup_ready = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0050; req_wdata[0] = 16'h0C0C;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("t4_psel_c%0d", k), psel[0], ((k % 3) != 0) && (k <= 8));
            check($sformatf("t4_rsp_c%0d", k), rsp_valid[0], ((k % 3) == 0) && (k <= 9));
            if (k == 7) req_valid[0] = 1'b0;
        end
        setup_ready = 1'b0;
        ref_mem[key(16'h0050)] = 16'h0C0C;

        // asynchronous reset in the middle of ACCESS
        waits[0] = 10;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h0021;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t5_in_access", penable[0], 1);
        #3 rst = 1'b1;
        #1;
        check("t5_psel", psel[0], 0);
        check("t5_penable", penable[0], 0);
        check("t5_req_ready", req_ready[0], 1);
        check("t5_paddr", paddr[0], 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) bad++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) bad++;
        end
        check("t5_no_rsp", bad, 0);
        waits[0] = 0;
        run("t5_after", 0, 1'b0, 16'h0021, 16'h0000, ref_mem[key(16'h0021)], 1'b0, 3);

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        wr, exp_to;
            logic [15:0] addr, wd, exp_rd;
            int          w, exp_lat;
            wr   = 1'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? 16'h8000 : {8'h00, 8'($urandom)};
            wd   = 16'($urandom);
            w    = $urandom_range(0, 5);
            waits[0] = w;
            if (w >= TO_A) begin
                exp_to = 1'b1; exp_rd = 16'h0000; exp_lat = 3 + TO_A - 1;
            end else begin
                exp_to = 1'b0; exp_lat = 3 + w;
                if (wr) begin exp_rd = 16'h0000; ref_mem[key(addr)] = wd; end
                else    exp_rd = ref_mem[key(addr)];
            end
            run($sformatf("rnd%0d", i), 0, wr, addr, wd, exp_rd, exp_to, exp_lat);
        end
        waits[0] = 0;

        // two masters sharing one bus: interleaved writes, then crossed readback
        shared = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sh_a[i] = 16'($urandom);
            sh_b[i] = 16'($urandom);
        end
        fork
            for (int i = 0; i < 6; i++) run("sh_wa", 0, 1'b1, 16'h0040 + 16'(i), sh_a[i], 16'h0000, 1'b0, -1);
            for (int j = 0; j < 6; j++) run("sh_wb", 1, 1'b1, 16'h0060 + 16'(j), sh_b[j], 16'h0000, 1'b0, -1);
        join
        for (int i = 0; i < 6; i++) begin
            ref_mem[key(16'h0040 + 16'(i))] = sh_a[i];
            ref_mem[key(16'h0060 + 16'(i))] = sh_b[i];
        end
        fork
            for (int i = 0; i < 6; i++) run("sh_ra", 0, 1'b0, 16'h0060 + 16'(i), 16'h0000, ref_mem[key(16'h0060 + 16'(i))], 1'b0, -1);
            for (int j = 0; j < 6; j++) run("sh_rb", 1, 1'b0, 16'h0040 + 16'(j), 16'h0000, ref_mem[key(16'h0040 + 16'(j))], 1'b0, -1);
        join
        run("sh_gpio_w", 0, 1'b1, 16'h8000, 16'h3C3C, 16'h0000, 1'b0, -1);
        run("sh_gpio_r", 1, 1'b0, 16'h8000, 16'h0000, 16'h3C3C, 1'b0, -1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
